// File: rtl/gx_fifo_pkg.sv
// Shared definitions for the GX FIFO writer: store-size encodings, word width,
// default depth/watermarks and a helper mapping store size to byte count.
// Optional feature macro used by gx_fifo_writer: GX_FIFO_WMARK_EN.
package gx_fifo_pkg;

  typedef enum logic [1:0] {
    GX_SZ_8   = 2'd0,
    GX_SZ_16  = 2'd1,
    GX_SZ_32  = 2'd2,
    GX_SZ_BAD = 2'd3
  } gx_size_e;

  localparam int GX_WORD_W       = 32;
  localparam int GX_DEPTH_DEF    = 32;
  localparam int GX_HI_WMARK_DEF = 24;
  localparam int GX_LO_WMARK_DEF = 8;

  // Bytes carried by a store; 0 marks the illegal encoding so it can be ignored.
  function automatic logic [2:0] gx_size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      GX_SZ_8:  n = 3'd1;
      GX_SZ_16: n = 3'd2;
      GX_SZ_32: n = 3'd4;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gx_wg_packer.sv
// Write-gather byte accumulator: merges big-endian 8/16/32-bit stores into
// 32-bit words. Push strobe and word are combinational from the current store
// and the registered acc/pc; at most one word completes per store.
module gx_wg_packer
  import gx_fifo_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 st_valid,
  input  logic [1:0]           st_size,
  input  logic [GX_WORD_W-1:0] st_data,
  output logic                 push,
  output logic [GX_WORD_W-1:0] push_word
);

  logic [1:0]  pc_reg, pc_next;
  logic [31:0] acc_reg, acc_next;
  logic [2:0]  nbytes;
  logic [2:0]  fill;
  logic [5:0]  lsh;
  logic [5:0]  rsh;
  logic [31:0] st_left;
  logic [63:0] merged;
  logic        take;

  // Left-justify the store, slide it to lane pc and split into word/remainder.
  always_comb begin
    nbytes    = gx_size_bytes(st_size);
    lsh       = {3'(3'd4 - nbytes), 3'b000};
    st_left   = st_data << lsh;
    rsh       = {1'b0, pc_reg, 3'b000};
    merged    = {acc_reg, 32'h0} | ({st_left, 32'h0} >> rsh);
    fill      = {1'b0, pc_reg} + nbytes;
    take      = st_valid && (nbytes != 3'd0);
    push      = take && fill[2];
    push_word = merged[63:32];
    pc_next   = pc_reg;
    acc_next  = acc_reg;
    if (take) begin
      // Lanes above the new pc stay zero, so OR-merging remains correct.
      pc_next  = fill[1:0];
      acc_next = fill[2] ? merged[31:0] : merged[63:32];
    end
  end

  // Accumulator state; clear discards any partial word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pc_reg  <= 2'd0;
      acc_reg <= 32'h0;
    end else begin
      pc_reg  <= pc_next;
      acc_reg <= acc_next;
    end
  end

endmodule

// File: rtl/gx_fifo_writer.sv
// Producer end of the GX FIFO link: packs CPU write-gather stores into words,
// buffers them in a circular FIFO and serves them first-word-fall-through.
// Optional watermark outputs are built when GX_FIFO_WMARK_EN is defined.
module gx_fifo_writer
  import gx_fifo_pkg::*;
#(
  parameter int DEPTH    = GX_DEPTH_DEF,
  parameter int HI_WMARK = GX_HI_WMARK_DEF,
  parameter int LO_WMARK = GX_LO_WMARK_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [1:0]               wr_size,
  input  logic [GX_WORD_W-1:0]     wr_data,
  output logic                     wr_ready,
  input  logic                     GXFIFORead,
  output logic                     GXFIFOValid,
  output logic [GX_WORD_W-1:0]     GXFIFOData,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef GX_FIFO_WMARK_EN
  ,
  output logic                     hi_wmark,
  output logic                     lo_wmark
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [GX_WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg, count_next;
  logic                 overflow_reg;
  logic                 st_valid;
  logic                 pk_push;
  logic [GX_WORD_W-1:0] pk_word;
  logic                 pop;

  // Handshake decode: flush suppresses any concurrent store or pop.
  always_comb begin
    wr_ready    = (count_reg < CW'(DEPTH));
    GXFIFOValid = (count_reg != '0);
    GXFIFOData  = GXFIFOValid ? mem[rd_ptr_reg] : '0;
    st_valid    = wr_en && wr_ready && !flush;
    pop         = GXFIFORead && GXFIFOValid && !flush;
    count_next  = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CW'(pk_push) - CW'(pop);
    end
  end

  gx_wg_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .st_valid  (st_valid),
    .st_size   (wr_size),
    .st_data   (wr_data),
    .push      (pk_push),
    .push_word (pk_word)
  );

  // Word storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (pk_push) begin
      mem[wr_ptr_reg] <= pk_word;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (pk_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      if (wr_en && !wr_ready) overflow_reg <= 1'b1;
    end
  end

  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

`ifdef GX_FIFO_WMARK_EN
  logic hi_reg, lo_reg;

  // Watermarks track the count that is about to be registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg <= 1'b0;
      lo_reg <= 1'b1;
    end else begin
      hi_reg <= (count_next >= CW'(HI_WMARK));
      lo_reg <= (count_next <= CW'(LO_WMARK));
    end
  end

  assign hi_wmark = hi_reg;
  assign lo_wmark = lo_reg;
`endif

endmodule

// File: tb/tb_gx_fifo_writer.sv
// Directed self-checking bench for gx_fifo_writer (default DEPTH=32).
module tb_gx_fifo_writer;
  import gx_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, wr_en, GXFIFORead;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;
  logic        wr_ready, GXFIFOValid, overflow;
  logic [31:0] GXFIFOData;
  logic [5:0]  fifo_count;
`ifdef GX_FIFO_WMARK_EN
  logic        hi_wmark, lo_wmark;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gx_fifo_writer dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_size     (wr_size),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .GXFIFORead  (GXFIFORead),
    .GXFIFOValid (GXFIFOValid),
    .GXFIFOData  (GXFIFOData),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
`ifdef GX_FIFO_WMARK_EN
    ,
    .hi_wmark    (hi_wmark),
    .lo_wmark    (lo_wmark)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_size = sz;
    wr_data = d;
    step();
    wr_en   = 1'b0;
    $display("store size=%0d data=%h count=%0d ready=%0b", sz, d, fifo_count, wr_ready);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; GXFIFORead = 1'b0;
    wr_size = 2'd0; wr_data = 32'h0;
    step(); step();
    reset = 1'b0;
    chk("rst_valid", 32'(GXFIFOValid), 32'd0);
    chk("rst_data", GXFIFOData, 32'h0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef GX_FIFO_WMARK_EN
    chk("rst_hi", 32'(hi_wmark), 32'd0);
    chk("rst_lo", 32'(lo_wmark), 32'd1);
`endif

    // Four byte stores form one word; partial word stays hidden.
    store(GX_SZ_8, 32'h11);
    store(GX_SZ_8, 32'h22);
    store(GX_SZ_8, 32'h33);
    chk("partial_hidden", 32'(GXFIFOValid), 32'd0);
    store(GX_SZ_8, 32'h44);
    chk("b4_valid", 32'(GXFIFOValid), 32'd1);
    chk("b4_count", 32'(fifo_count), 32'd1);
    chk("b4_data", GXFIFOData, 32'h11223344);
    GXFIFORead = 1'b1;
    step();
    GXFIFORead = 1'b0;
    chk("b4_popped", 32'(fifo_count), 32'd0);

    // Mixed sizes straddling word boundaries.
    store(GX_SZ_8, 32'hAA);
    store(GX_SZ_32, 32'h01020304);
    store(GX_SZ_16, 32'hBBCC);
    store(GX_SZ_8, 32'hDD);
    chk("mix_count", 32'(fifo_count), 32'd2);
    GXFIFORead = 1'b1;
    chk("mix_w0", GXFIFOData, 32'hAA010203);
    step();
    chk("mix_w1", GXFIFOData, 32'h04BBCCDD);
    step();
    GXFIFORead = 1'b0;
    chk("mix_empty", 32'(GXFIFOValid), 32'd0);

    // Fill to DEPTH, then a refused store even while popping.
    for (int i = 0; i < 32; i++) store(GX_SZ_32, 32'(i));
    chk("full_count", 32'(fifo_count), 32'd32);
    chk("full_ready", 32'(wr_ready), 32'd0);
    chk("full_ovf0", 32'(overflow), 32'd0);
    GXFIFORead = 1'b1;
    store(GX_SZ_32, 32'hDEAD);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(fifo_count), 32'd31);
    chk("drop_head", GXFIFOData, 32'd1);
    for (int i = 1; i < 32; i++) begin
      chk($sformatf("drain_%0d", i), GXFIFOData, 32'(i));
      step();
    end
    GXFIFORead = 1'b0;
    chk("drain_empty", 32'(GXFIFOValid), 32'd0);
    chk("drain_ready", 32'(wr_ready), 32'd1);

    // Steady push+pop at count=1 across several pointer wraps.
    store(GX_SZ_32, 32'h1000);
    for (int k = 1; k <= 100; k++) begin
      GXFIFORead = 1'b1;
      chk($sformatf("pp_data_%0d", k), GXFIFOData, 32'h1000 + 32'(k - 1));
      store(GX_SZ_32, 32'h1000 + 32'(k));
      chk($sformatf("pp_count_%0d", k), 32'(fifo_count), 32'd1);
    end
    chk("pp_last", GXFIFOData, 32'h1000 + 32'd100);
    step();
    GXFIFORead = 1'b0;
    chk("pp_empty", 32'(fifo_count), 32'd0);

    // Illegal size is ignored and does not disturb byte alignment.
    store(GX_SZ_BAD, 32'hFFFFFFFF);
    store(GX_SZ_16, 32'h5566);
    store(GX_SZ_16, 32'h7788);
    chk("bad_word", GXFIFOData, 32'h55667788);
    chk("bad_count", 32'(fifo_count), 32'd1);

    // Flush with queued words, a partial word, a pop and a store all at once.
    store(GX_SZ_32, 32'hA0);
    store(GX_SZ_32, 32'hA1);
    store(GX_SZ_8, 32'hE1);
    store(GX_SZ_8, 32'hE2);
    chk("preflush_count", 32'(fifo_count), 32'd3);
    flush = 1'b1; GXFIFORead = 1'b1;
    store(GX_SZ_16, 32'h9999);
    flush = 1'b0; GXFIFORead = 1'b0;
    chk("flush_count", 32'(fifo_count), 32'd0);
    chk("flush_valid", 32'(GXFIFOValid), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'd0);
    store(GX_SZ_32, 32'hCAFEF00D);
    chk("postflush_count", 32'(fifo_count), 32'd1);
    chk("postflush_data", GXFIFOData, 32'hCAFEF00D);

    // Reset mid-operation discards everything on that edge.
    store(GX_SZ_8, 32'h77);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_valid", 32'(GXFIFOValid), 32'd0);
    store(GX_SZ_32, 32'h0BADF00D);
    chk("midrst_word", GXFIFOData, 32'h0BADF00D);
    GXFIFORead = 1'b1;
    step();
    GXFIFORead = 1'b0;

`ifdef GX_FIFO_WMARK_EN
    for (int i = 0; i < 23; i++) store(GX_SZ_32, 32'(i));
    chk("wm_hi23", 32'(hi_wmark), 32'd0);
    store(GX_SZ_32, 32'd23);
    chk("wm_hi24", 32'(hi_wmark), 32'd1);
    chk("wm_lo24", 32'(lo_wmark), 32'd0);
    GXFIFORead = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("wm_lo9", 32'(lo_wmark), 32'd0);
    step();
    GXFIFORead = 1'b0;
    chk("wm_cnt8", 32'(fifo_count), 32'd8);
    chk("wm_lo8", 32'(lo_wmark), 32'd1);
    chk("wm_hi8", 32'(hi_wmark), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
